// File: rtl/eth_tx_frame_scheduler_if.sv
// AXI-stream byte channel (8-bit tdata with tlast/tuser) between a frame source and its sink.
interface eth_tx_frame_scheduler_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/eth_tx_frame_scheduler.sv
// Whole-frame 2:1 scheduler (round-robin or source-1 priority) with PAUSE hold-off of source 0.
// Latency: grant one cycle after request, zero-latency datapath, one idle cycle between frames.
// Backpressure: m_axis tready goes straight to the granted source; the other source sees tready=0.
module eth_tx_frame_scheduler #(
    parameter string ARB_MODE     = "ROUND_ROBIN",
    parameter bit    PAUSE_ENABLE = 1'b1,
    parameter int    CNT_WIDTH    = 16
) (
    input  logic                     tx_clk,
    input  logic                     tx_rst,
    eth_tx_frame_scheduler_if.slave  s0_axis,
    eth_tx_frame_scheduler_if.slave  s1_axis,
    eth_tx_frame_scheduler_if.master m_axis,
    input  logic                     pause_req_valid,
    input  logic [15:0]              pause_req_quanta,
    input  logic                     pause_tick,
    output logic                     paused,
    output logic [15:0]              pause_remaining,
    output logic [1:0]               grant,
    output logic [CNT_WIDTH-1:0]     s0_frame_count,
    output logic [CNT_WIDTH-1:0]     s1_frame_count
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam bit                 PRIO_MODE = (ARB_MODE == "PRIORITY");
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic                 last_q, last_d;      // 1: source 1 was served last
    logic [15:0]          pause_q, pause_d;
    logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

    logic       e0, e1;
    logic [1:0] pick;
    logic       sel1;
    logic [7:0] sel_tdata;
    logic       sel_tvalid, sel_tlast, sel_tuser;

    assign paused          = (pause_q != 16'd0);
    assign pause_remaining = pause_q;
    assign grant           = grant_q;
    assign s0_frame_count  = cnt0_q;
    assign s1_frame_count  = cnt1_q;

    assign e0 = s0_axis.tvalid & ~paused;
    assign e1 = s1_axis.tvalid;

    // Both eligible in round-robin: serve whichever source did not go last.
    always_comb begin
        pick = 2'b00;
        if (PRIO_MODE) begin
            pick = e1 ? 2'b10 : 2'b01;
        end else if (e0 && e1) begin
            pick = last_q ? 2'b01 : 2'b10;
        end else if (e1) begin
            pick = 2'b10;
        end else begin
            pick = 2'b01;
        end
    end

    assign sel1       = grant_q[1];
    assign sel_tdata  = sel1 ? s1_axis.tdata  : s0_axis.tdata;
    assign sel_tvalid = sel1 ? s1_axis.tvalid : s0_axis.tvalid;
    assign sel_tlast  = sel1 ? s1_axis.tlast  : s0_axis.tlast;
    assign sel_tuser  = sel1 ? s1_axis.tuser  : s0_axis.tuser;

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_d         = last_q;
        cnt0_d         = cnt0_q;
        cnt1_d         = cnt1_q;
        m_axis.tdata   = 8'h00;
        m_axis.tvalid  = 1'b0;
        m_axis.tlast   = 1'b0;
        m_axis.tuser   = 1'b0;
        s0_axis.tready = 1'b0;
        s1_axis.tready = 1'b0;
        case (state_q)
            IDLE: begin
                if (e0 || e1) begin
                    grant_d = pick;
                    state_d = XFER;
                end
            end
            XFER: begin
                m_axis.tdata  = sel_tdata;
                m_axis.tvalid = sel_tvalid;
                m_axis.tlast  = sel_tlast;
                m_axis.tuser  = sel_tuser;
                if (sel1) begin
                    s1_axis.tready = m_axis.tready;
                end else begin
                    s0_axis.tready = m_axis.tready;
                end
                if (sel_tvalid && m_axis.tready && sel_tlast) begin
                    if (sel1) begin
                        cnt1_d = cnt1_q + CNT_ONE;
                    end else begin
                        cnt0_d = cnt0_q + CNT_ONE;
                    end
                    last_d  = sel1;
                    grant_d = 2'b00;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    // A load always wins over a tick arriving in the same cycle.
    always_comb begin
        pause_d = pause_q;
        if (!PAUSE_ENABLE) begin
            pause_d = 16'd0;
        end else if (pause_req_valid) begin
            pause_d = pause_req_quanta;
        end else if (pause_tick && (pause_q != 16'd0)) begin
            pause_d = pause_q - 16'd1;
        end
    end

    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            pause_q <= 16'd0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            pause_q <= pause_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_scheduler.sv
// Scoreboard bench for eth_tx_frame_scheduler: round-robin, pause, backpressure, reset, priority/wrap.
`timescale 1ns/1ps
module tb_eth_tx_frame_scheduler;

    logic tx_clk = 1'b0;
    logic tx_rst;
    always #5 tx_clk = ~tx_clk;

    eth_tx_frame_scheduler_if s0_if ();
    eth_tx_frame_scheduler_if s1_if ();
    eth_tx_frame_scheduler_if m_if ();
    eth_tx_frame_scheduler_if p_s0_if ();
    eth_tx_frame_scheduler_if p_s1_if ();
    eth_tx_frame_scheduler_if p_m_if ();

    logic        pause_req_valid;
    logic [15:0] pause_req_quanta;
    logic        pause_tick;
    logic        paused;
    logic [15:0] pause_remaining;
    logic [1:0]  grant;
    logic [15:0] s0_frame_count, s1_frame_count;

    logic        p_paused;
    logic [15:0] p_pause_remaining;
    logic [1:0]  p_grant;
    logic [1:0]  p_s0_cnt, p_s1_cnt;

    eth_tx_frame_scheduler dut (
        .tx_clk           (tx_clk),
        .tx_rst           (tx_rst),
        .s0_axis          (s0_if),
        .s1_axis          (s1_if),
        .m_axis           (m_if),
        .pause_req_valid  (pause_req_valid),
        .pause_req_quanta (pause_req_quanta),
        .pause_tick       (pause_tick),
        .paused           (paused),
        .pause_remaining  (pause_remaining),
        .grant            (grant),
        .s0_frame_count   (s0_frame_count),
        .s1_frame_count   (s1_frame_count)
    );

    eth_tx_frame_scheduler #(.ARB_MODE("PRIORITY"), .CNT_WIDTH(2)) dut_prio (
        .tx_clk           (tx_clk),
        .tx_rst           (tx_rst),
        .s0_axis          (p_s0_if),
        .s1_axis          (p_s1_if),
        .m_axis           (p_m_if),
        .pause_req_valid  (1'b0),
        .pause_req_quanta (16'd0),
        .pause_tick       (1'b0),
        .paused           (p_paused),
        .pause_remaining  (p_pause_remaining),
        .grant            (p_grant),
        .s0_frame_count   (p_s0_cnt),
        .s1_frame_count   (p_s1_cnt)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [9:0] exp_q0[$];
    logic [9:0] exp_q1[$];
    logic [1:0] glog[$];
    int         gaps[$];
    bit         sb_en = 1'b1;
    bit         bp_rand = 1'b0;
    bit         bp_level = 1'b1;
    int         exp_c0 = 0;
    int         exp_c1 = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic present(input int src, input logic [7:0] d, input logic l, input logic u);
        if (src == 1) begin
            s1_if.tdata = d; s1_if.tvalid = 1'b1; s1_if.tlast = l; s1_if.tuser = u;
            exp_q1.push_back({d, l, u});
        end else begin
            s0_if.tdata = d; s0_if.tvalid = 1'b1; s0_if.tlast = l; s0_if.tuser = u;
            exp_q0.push_back({d, l, u});
        end
    endtask

    task automatic idle_src(input int src);
        if (src == 1) begin
            s1_if.tvalid = 1'b0; s1_if.tlast = 1'b0; s1_if.tuser = 1'b0;
        end else begin
            s0_if.tvalid = 1'b0; s0_if.tlast = 1'b0; s0_if.tuser = 1'b0;
        end
    endtask

    task automatic wait_hs(input int src);
        int n = 0;
        bit hs = 1'b0;
        while (!hs && n < 500) begin
            @(negedge tx_clk);
            n++;
            hs = (src == 1) ? (s1_if.tvalid && s1_if.tready) : (s0_if.tvalid && s0_if.tready);
        end
        chk((src == 1) ? "s1_handshake" : "s0_handshake", hs, 1);
    endtask

    task automatic send_frame(input int src, input int len, input logic [7:0] base, input logic user);
        for (int i = 0; i < len; i++) begin
            present(src, base + 8'(i), (i == len - 1), user && (i == len - 1));
            wait_hs(src);
            step();
        end
        idle_src(src);
        if (src == 1) exp_c1++; else exp_c0++;
    endtask

    task automatic monitor();
        bit         in_frame = 1'b0;
        int         last_end = -1;
        int         cyc = 0;
        logic [9:0] got;
        forever begin
            @(negedge tx_clk);
            cyc++;
            if (tx_rst || !sb_en) begin
                in_frame = 1'b0;
                last_end = -1;
            end else if (m_if.tvalid && m_if.tready) begin
                chk("grant_onehot", (grant == 2'b01 || grant == 2'b10), 1);
                if (!in_frame) begin
                    glog.push_back(grant);
                    if (last_end >= 0) gaps.push_back(cyc - last_end);
                    in_frame = 1'b1;
                end
                got = {m_if.tdata, m_if.tlast, m_if.tuser};
                if (grant[1]) begin
                    chk("sb1_avail", exp_q1.size() != 0, 1);
                    if (exp_q1.size() != 0) chk("s1_beat", got, exp_q1.pop_front());
                end else begin
                    chk("sb0_avail", exp_q0.size() != 0, 1);
                    if (exp_q0.size() != 0) chk("s0_beat", got, exp_q0.pop_front());
                end
                if (m_if.tlast) begin
                    in_frame = 1'b0;
                    last_end = cyc;
                end
            end
        end
    endtask

    task automatic bp_drive();
        forever begin
            @(posedge tx_clk);
            #1;
            m_if.tready = bp_rand ? 1'($urandom_range(0, 1)) : bp_level;
        end
    endtask

    initial begin
        logic [1:0] rr_exp [4];
        int gl_base, gp_base;
        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};

        tx_rst = 1'b1;
        pause_req_valid = 1'b0; pause_req_quanta = 16'd0; pause_tick = 1'b0;
        s0_if.tdata = 8'h00; s0_if.tvalid = 1'b0; s0_if.tlast = 1'b0; s0_if.tuser = 1'b0;
        s1_if.tdata = 8'h00; s1_if.tvalid = 1'b0; s1_if.tlast = 1'b0; s1_if.tuser = 1'b0;
        p_s0_if.tdata = 8'h00; p_s0_if.tvalid = 1'b0; p_s0_if.tlast = 1'b0; p_s0_if.tuser = 1'b0;
        p_s1_if.tdata = 8'h00; p_s1_if.tvalid = 1'b0; p_s1_if.tlast = 1'b0; p_s1_if.tuser = 1'b0;
        m_if.tready = 1'b1;
        p_m_if.tready = 1'b1;
        fork
            monitor();
            bp_drive();
        join_none

        // Reset state
        step();
        step();
        chk("rst_m_tvalid", m_if.tvalid, 0);
        chk("rst_m_tdata", m_if.tdata, 0);
        chk("rst_s0_tready", s0_if.tready, 0);
        chk("rst_s1_tready", s1_if.tready, 0);
        chk("rst_grant", grant, 0);
        chk("rst_paused", paused, 0);
        chk("rst_pause_rem", pause_remaining, 0);
        chk("rst_s0_cnt", s0_frame_count, 0);
        chk("rst_s1_cnt", s1_frame_count, 0);
        tx_rst = 1'b0;
        step();

        // Round-robin alternation with continuously offered 4-beat frames
        gl_base = glog.size();
        gp_base = gaps.size();
        fork
            begin send_frame(0, 4, 8'h10, 1'b0); send_frame(0, 4, 8'h20, 1'b1); end
            begin send_frame(1, 4, 8'h80, 1'b1); send_frame(1, 4, 8'h90, 1'b0); end
        join
        chk("rr_nframes", glog.size() - gl_base, 4);
        for (int i = 0; i < 4; i++)
            if (gl_base + i < glog.size()) chk("rr_grant_seq", glog[gl_base + i], rr_exp[i]);
        chk("rr_ngaps", gaps.size() - gp_base, 3);
        for (int i = gp_base; i < gaps.size(); i++) chk("rr_bubble", gaps[i], 2);
        chk("rr_s0_cnt", s0_frame_count, 2);
        chk("rr_s1_cnt", s1_frame_count, 2);

        // Pause hold-off: source 1 passes, source 0 waits for three ticks
        step();
        pause_req_valid = 1'b1; pause_req_quanta = 16'd3;
        step();
        pause_req_valid = 1'b0;
        chk("ph_paused", paused, 1);
        chk("ph_rem", pause_remaining, 3);
        present(0, 8'hC0, 1'b1, 1'b0);
        send_frame(1, 2, 8'hD0, 1'b0);
        chk("ph_s0_blocked", s0_if.tready, 0);
        chk("ph_grant_idle", grant, 0);
        for (int k = 1; k <= 3; k++) begin
            pause_tick = 1'b1;
            step();
            pause_tick = 1'b0;
            chk("ph_tick_rem", pause_remaining, 3 - k);
            chk("ph_tick_paused", paused, (k < 3));
            chk("ph_tick_grant", grant, 0);
            chk("ph_tick_s0_rdy", s0_if.tready, 0);
        end
        step();
        chk("ph_s0_granted", grant, 2'b01);
        chk("ph_s0_rdy", s0_if.tready, 1);
        wait_hs(0);
        step();
        idle_src(0);
        exp_c0++;

        // Simultaneous load and tick, then load of zero
        pause_req_valid = 1'b1; pause_req_quanta = 16'd2;
        step();
        chk("lt_rem2", pause_remaining, 2);
        pause_req_quanta = 16'd7; pause_tick = 1'b1;
        step();
        pause_req_valid = 1'b0; pause_tick = 1'b0;
        chk("lt_rem7", pause_remaining, 7);
        pause_req_valid = 1'b1; pause_req_quanta = 16'd0;
        step();
        pause_req_valid = 1'b0;
        chk("lt_clr_paused", paused, 0);
        chk("lt_clr_rem", pause_remaining, 0);

        // Pause loaded mid-frame: frame completes, next source-0 frame is held
        fork
            send_frame(0, 4, 8'hA0, 1'b1);
            begin
                step();
                step();
                pause_req_valid = 1'b1; pause_req_quanta = 16'd5;
                step();
                pause_req_valid = 1'b0;
            end
        join
        chk("pf_paused", paused, 1);
        chk("pf_s0_cnt", s0_frame_count, exp_c0);
        present(0, 8'hB0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("pf_hold_grant", grant, 0);
            chk("pf_hold_rdy", s0_if.tready, 0);
        end
        pause_req_valid = 1'b1; pause_req_quanta = 16'd0;
        step();
        pause_req_valid = 1'b0;
        chk("pf_clr_paused", paused, 0);
        step();
        chk("pf_s0_granted", grant, 2'b01);
        wait_hs(0);
        step();
        idle_src(0);
        exp_c0++;

        // Random backpressure, interleaved sources
        bp_rand = 1'b1;
        fork
            for (int f = 0; f < 4; f++) send_frame(0, 1 + $urandom_range(0, 5), 8'(8'h40 + 16 * f), f[0]);
            for (int f = 0; f < 4; f++) send_frame(1, 1 + $urandom_range(0, 5), 8'(8'hC0 + 8 * f), ~f[0]);
        join
        bp_rand = 1'b0;
        step();
        step();
        chk("bp_q0_drained", exp_q0.size(), 0);
        chk("bp_q1_drained", exp_q1.size(), 0);
        chk("bp_s0_cnt", s0_frame_count, exp_c0);
        chk("bp_s1_cnt", s1_frame_count, exp_c1);

        // Reset mid-frame, after source 0 was served last
        send_frame(0, 1, 8'h11, 1'b0);
        sb_en = 1'b0;
        bp_level = 1'b0;
        step();
        s0_if.tdata = 8'h5A; s0_if.tvalid = 1'b1; s0_if.tlast = 1'b0; s0_if.tuser = 1'b0;
        s1_if.tdata = 8'h6B; s1_if.tvalid = 1'b1; s1_if.tlast = 1'b1; s1_if.tuser = 1'b1;
        step();
        chk("rm_grant_s1", grant, 2'b10);
        chk("rm_m_tdata", m_if.tdata, 8'h6B);
        pause_req_valid = 1'b1; pause_req_quanta = 16'd9;
        step();
        pause_req_valid = 1'b0;
        #2;
        tx_rst = 1'b1;
        #1;
        chk("rm_m_tvalid", m_if.tvalid, 0);
        chk("rm_m_tdata0", m_if.tdata, 0);
        chk("rm_m_tlast", m_if.tlast, 0);
        chk("rm_m_tuser", m_if.tuser, 0);
        chk("rm_s0_rdy", s0_if.tready, 0);
        chk("rm_s1_rdy", s1_if.tready, 0);
        chk("rm_grant", grant, 0);
        chk("rm_paused", paused, 0);
        chk("rm_rem", pause_remaining, 0);
        chk("rm_s0_cnt", s0_frame_count, 0);
        chk("rm_s1_cnt", s1_frame_count, 0);
        step();
        tx_rst = 1'b0;
        bp_level = 1'b1;
        step();
        chk("rm_after_s0_first", grant, 2'b01);
        s0_if.tlast = 1'b1;
        step();
        step();
        idle_src(0);
        idle_src(1);
        step();

        // Priority mode and frame-counter wrap (CNT_WIDTH = 2)
        p_s0_if.tdata = 8'hA0; p_s0_if.tvalid = 1'b1; p_s0_if.tlast = 1'b1;
        p_s1_if.tdata = 8'hB0; p_s1_if.tvalid = 1'b1; p_s1_if.tlast = 1'b1;
        step();
        chk("pr_grant_s1", p_grant, 2'b10);
        chk("pr_tdata_b0", p_m_if.tdata, 8'hB0);
        chk("pr_s0_rdy", p_s0_if.tready, 0);
        step();
        p_s1_if.tdata = 8'hB1;
        chk("pr_bubble", p_grant, 0);
        step();
        chk("pr_grant_s1_again", p_grant, 2'b10);
        chk("pr_tdata_b1", p_m_if.tdata, 8'hB1);
        step();
        p_s1_if.tvalid = 1'b0;
        step();
        chk("pr_grant_s0", p_grant, 2'b01);
        chk("pr_tdata_a0", p_m_if.tdata, 8'hA0);
        step();
        p_s0_if.tvalid = 1'b0;
        chk("pr_s0_cnt", p_s0_cnt, 1);
        chk("pr_s1_cnt", p_s1_cnt, 2);
        p_s1_if.tvalid = 1'b1;
        for (int k = 0; k < 4; k++) step();
        p_s1_if.tvalid = 1'b0;
        chk("pr_s1_cnt_wrap", p_s1_cnt, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
